// File: rtl/text_fetch_ctrl.sv
// Character/font fetch sequencer for an 80x30 text display, with text-RAM write arbitration.
// Optional blinking cursor overlay enabled by defining TEXT_CURSOR_EN.
module text_fetch_ctrl #(
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned H_CELLS = 100,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned TRAM_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_tick,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  output logic [TRAM_AW-1:0] tram_addr,
  output logic               tram_we,
  output logic [6:0]         tram_wdata,
  input  logic [6:0]         tram_rdata,
  output logic [10:0]        rom_addr,
  input  logic [7:0]         rom_data,
  input  logic               wr_req,
  input  logic [TRAM_AW-1:0] wr_addr,
  input  logic [6:0]         wr_char,
  output logic               wr_ack,
  output logic               pixel_on,
  output logic               fetch_late
`ifdef TEXT_CURSOR_EN
  ,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row
`endif
);

  localparam int unsigned VIS_LINES = ROWS * 16;

  typedef enum logic [1:0] {S_IDLE, S_TRAM, S_ROM, S_LOAD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_col;
  logic [9:0]         r_line;
  logic [7:0]         r_next_word;
  logic [7:0]         r_active_word;
  logic               r_pixel_on;
  logic               r_fetch_late;

  logic [6:0]         w_cell;
  logic               w_trigger;
  logic               w_boundary;
  logic               w_tgt_valid;
  logic               w_tgt_vis;
  logic [6:0]         w_tgt_col;
  logic [9:0]         w_tgt_line;
  logic               w_start;
  logic               w_grant;
  logic               w_abort;
  logic               w_pix_bit;
  logic               w_cursor_inv;
  logic [TRAM_AW-1:0] w_fetch_addr;

  assign w_cell     = pixel_x[9:3];
  assign w_trigger  = pixel_tick & (pixel_x[2:0] == 3'd5);
  assign w_boundary = pixel_tick & (pixel_x[2:0] == 3'd7);

  // Target cell for the fetch: next column on this line, or column 0 of the next line
  always_comb begin
    w_tgt_valid = 1'b0;
    w_tgt_col   = '0;
    w_tgt_line  = pixel_y;
    if (32'(w_cell) + 32'd1 < COLS) begin
      w_tgt_valid = 1'b1;
      w_tgt_col   = w_cell + 7'd1;
    end else if (32'(w_cell) == H_CELLS - 32'd1) begin
      w_tgt_valid = 1'b1;
      w_tgt_line  = (32'(pixel_y) == V_TOTAL - 32'd1) ? 10'd0 : pixel_y + 10'd1;
    end
  end

  assign w_tgt_vis    = 32'(w_tgt_line) < VIS_LINES;
  assign w_start      = w_trigger & w_tgt_valid & w_tgt_vis;
  assign w_grant      = ~reset & (r_state == S_IDLE) & ~w_trigger & wr_req;
  assign w_abort      = w_boundary & (r_state != S_IDLE);
  assign w_fetch_addr = TRAM_AW'(32'(r_line[9:4]) * COLS + 32'(r_col));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and the combinational memory-port controls
  always_comb begin
    w_state_nxt = r_state;
    tram_addr   = '0;
    tram_we     = 1'b0;
    tram_wdata  = '0;
    wr_ack      = 1'b0;
    rom_addr    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_TRAM;
        end else if (w_grant) begin
          tram_addr  = wr_addr;
          tram_we    = 1'b1;
          tram_wdata = wr_char;
          wr_ack     = 1'b1;
        end
      end
      S_TRAM: begin
        tram_addr   = w_fetch_addr;
        w_state_nxt = S_ROM;
      end
      S_ROM: begin
        rom_addr    = {tram_rdata, r_line[3:0]};
        w_state_nxt = S_LOAD;
      end
      S_LOAD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

`ifdef TEXT_CURSOR_EN
  logic [5:0] r_frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_frame_cnt <= '0;
    else if (pixel_tick && pixel_x == '0 && pixel_y == '0) r_frame_cnt <= r_frame_cnt + 6'd1;
  end

  assign w_cursor_inv = r_frame_cnt[5] & (w_cell == cursor_col) &
                        (pixel_y[9:4] == {1'b0, cursor_row});
`else
  assign w_cursor_inv = 1'b0;
`endif

  assign w_pix_bit = r_active_word[3'd7 - pixel_x[2:0]];

  // Fetch datapath, word hand-over at cell boundary, pixel serialiser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col         <= '0;
      r_line        <= '0;
      r_next_word   <= '0;
      r_active_word <= '0;
      r_pixel_on    <= 1'b0;
      r_fetch_late  <= 1'b0;
    end else begin
      if (w_start && r_state == S_IDLE) begin
        r_col  <= w_tgt_col;
        r_line <= w_tgt_line;
      end
      if (w_trigger && w_tgt_valid && !w_tgt_vis) r_next_word <= '0;
      else if (r_state == S_LOAD && !w_abort)    r_next_word <= rom_data;
      if (w_boundary) begin
        if (r_state != S_IDLE) begin
          r_active_word <= '0;
          r_fetch_late  <= 1'b1;
        end else begin
          r_active_word <= r_next_word;
        end
      end
      if (pixel_tick) r_pixel_on <= video_on & (w_pix_bit ^ w_cursor_inv);
    end
  end

  assign pixel_on   = r_pixel_on;
  assign fetch_late = r_fetch_late;

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Self-checking bench for text_fetch_ctrl: address vectors table, writer arbitration
// sequences, and a pixel scoreboard fed from text-RAM/font-ROM models.
module tb_text_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] tram_addr;
  logic        tram_we;
  logic [6:0]  tram_wdata;
  logic [6:0]  tram_rdata;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [6:0]  wr_char;
  logic        wr_ack;
  logic        pixel_on;
  logic        fetch_late;
`ifdef TEXT_CURSOR_EN
  logic [6:0]  cursor_col = 7'h7f;
  logic [4:0]  cursor_row = 5'h1f;
`endif

  always #5 clk = ~clk;

  text_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .tram_addr(tram_addr), .tram_we(tram_we),
    .tram_wdata(tram_wdata), .tram_rdata(tram_rdata), .rom_addr(rom_addr),
    .rom_data(rom_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_char(wr_char),
    .wr_ack(wr_ack), .pixel_on(pixel_on), .fetch_late(fetch_late)
`ifdef TEXT_CURSOR_EN
    , .cursor_col(cursor_col), .cursor_row(cursor_row)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] font_val(input logic [10:0] a);
    if (a == 11'h410) return 8'h18;
    return 8'(32'(a) * 29 + 7) | 8'h01;
  endfunction

  // Text RAM and font ROM models, both with one clock of read latency
  logic [6:0] tram_mem [0:4095];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) tram_mem[i] <= 7'(i * 5 + 33);
      tram_rdata <= '0;
      rom_data   <= '0;
    end else begin
      if (tram_we) tram_mem[tram_addr] <= tram_wdata;
      tram_rdata <= tram_mem[tram_addr];
      rom_data   <= font_val(rom_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_pix(input int x, input int y);
    logic [7:0] w;
    logic [6:0] ch;
    if (x >= 640 || y >= 480) return 1'b0;
    ch = tram_mem[12'((y / 16) * 80 + x / 8)];
    w  = font_val({ch, 4'(y % 16)});
    return w[3'(7 - x % 8)];
  endfunction

  // Pixel scoreboard: pushed as ticks are driven, popped when the registered pixel appears
  typedef struct { bit care; logic exp; int x; int y; } sb_t;
  sb_t  sb_q[$];
  logic mon_en = 1'b0;
  logic tick_q = 1'b0;
  always @(posedge clk) tick_q <= pixel_tick;
  always @(negedge clk) begin
    if (mon_en && tick_q) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got empty queue expected entry");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.care) check($sformatf("pixel x=%0d y=%0d", e.x, e.y), 32'(pixel_on), 32'(e.exp));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_tick(input int x, input int y);
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    video_on   = (x < 640) && (y < 480);
    pixel_tick = 1'b1;
  endtask

  task automatic tick_at(input int x, input int y);
    drive_tick(x, y);
    @(negedge clk);
    pixel_tick = 1'b0;
  endtask

  // xs must sit on a trigger pixel so that the cell after it is fully fetched
  task automatic stream(input int xs, input int ys, input int n, input int gap, input bit zero_exp);
    int x = xs;
    int y = ys;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{care: (i >= 3), exp: (zero_exp ? 1'b0 : exp_pix(x, y)), x: x, y: y});
      drive_tick(x, y);
      @(negedge clk);
      pixel_tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
      x++;
      if (x == 800) begin
        x = 0;
        y = (y == 524) ? 0 : y + 1;
      end
    end
    cyc(2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  typedef struct { int x; int y; bit fetch; int addr; int low; } vec_t;
  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  ack_cyc;
    int  ack_cnt;
    int  we_bad;
    bit  acked;

    vecs[0]  = '{5,   0,   1'b1, 1,    0};
    vecs[1]  = '{797, 15,  1'b1, 80,   0};
    vecs[2]  = '{797, 524, 1'b1, 0,    0};
    vecs[3]  = '{629, 0,   1'b1, 79,   0};
    vecs[4]  = '{637, 0,   1'b0, 0,    0};
    vecs[5]  = '{645, 0,   1'b0, 0,    0};
    vecs[6]  = '{789, 0,   1'b0, 0,    0};
    vecs[7]  = '{13,  479, 1'b1, 2322, 15};
    vecs[8]  = '{797, 479, 1'b0, 0,    0};
    vecs[9]  = '{21,  480, 1'b0, 0,    0};
    vecs[10] = '{797, 478, 1'b1, 2320, 15};
    vecs[11] = '{85,  37,  1'b1, 171,  5};
    vecs[12] = '{4,   0,   1'b0, 0,    0};
    vecs[13] = '{53,  100, 1'b1, 487,  4};

    reset = 1'b1; mem_init = 1'b1;
    pixel_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_char = '0;
    cyc(3);
    check("rst_tram_addr", 32'(tram_addr), 32'd0);
    check("rst_tram_we", 32'(tram_we), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_pixel_on", 32'(pixel_on), 32'd0);
    check("rst_fetch_late", 32'(fetch_late), 32'd0);
    mem_init = 1'b0;
    reset = 1'b0;
    cyc(2);

    // Fetch address table: text-RAM address in S_TRAM, font address in S_ROM
    foreach (vecs[i]) begin
      tick_at(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_tram_addr", i), 32'(tram_addr),
            vecs[i].fetch ? 32'(vecs[i].addr) : 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_rom_addr", i), 32'(rom_addr),
            vecs[i].fetch ? 32'({tram_mem[12'(vecs[i].addr)], 4'(vecs[i].low)}) : 32'd0);
      cyc(3);
    end

    // Reset while in S_ROM with a write pending
    tick_at(5, 3);
    @(negedge clk);
    check("rom_before_reset", 32'(rom_addr), 32'({tram_mem[1], 4'd3}));
    wr_addr = 12'd7; wr_char = 7'h09; wr_req = 1'b1; reset = 1'b1;
    #1;
    check("midrst_tram_addr", 32'(tram_addr), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    check("midrst_tram_we", 32'(tram_we), 32'd0);
    check("midrst_wr_ack", 32'(wr_ack), 32'd0);
    @(negedge clk);
    check("midrst_wr_ack_2", 32'(wr_ack), 32'd0);
    check("midrst_pixel_on", 32'(pixel_on), 32'd0);
    reset = 1'b0;
    #1;
    check("postrst_wr_ack", 32'(wr_ack), 32'd1);
    check("postrst_tram_addr", 32'(tram_addr), 32'd7);
    check("postrst_wdata", 32'(tram_wdata), 32'h09);
    @(negedge clk);
    wr_req = 1'b0;
    cyc(2);

    // Write request raised together with a fetch trigger: acked once the fetch is done
    wr_addr = 12'd0; wr_char = 7'h41; wr_req = 1'b1;
    drive_tick(5, 0);
    #1;
    check("trig_blocks_ack", 32'(wr_ack), 32'd0);
    ack_cyc = -1; ack_cnt = 0; we_bad = 0; acked = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pixel_tick = 1'b0;
      if (acked) wr_req = 1'b0;
      #1;
      if (tram_we != wr_ack) we_bad++;
      if (wr_ack) begin
        ack_cnt++;
        if (!acked) begin
          ack_cyc = k;
          acked   = 1'b1;
          check("wr_addr_out", 32'(tram_addr), 32'd0);
          check("wr_data_out", 32'(tram_wdata), 32'h41);
        end
      end
    end
    check("ack_cycle", 32'(ack_cyc), 32'd4);
    check("ack_count", 32'(ack_cnt), 32'd1);
    check("we_vs_ack", 32'(we_bad), 32'd0);

    // Back-to-back grants on consecutive idle clocks
    wr_addr = 12'h100; wr_char = 7'h11; wr_req = 1'b1;
    #1;
    check("b2b_ack0", 32'(wr_ack), 32'd1);
    @(negedge clk);
    wr_addr = 12'h101; wr_char = 7'h12;
    #1;
    check("b2b_ack1", 32'(wr_ack), 32'd1);
    check("b2b_addr1", 32'(tram_addr), 32'h101);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    check("b2b_mem0", 32'(tram_mem[12'h100]), 32'h11);

    // Trigger on a blanking cell: no fetch, pending write goes through next clock
    wr_addr = 12'd5; wr_char = 7'h22; wr_req = 1'b1;
    drive_tick(645, 0);
    #1;
    check("blank_trig_ack", 32'(wr_ack), 32'd0);
    @(negedge clk);
    pixel_tick = 1'b0;
    #1;
    check("blank_ack", 32'(wr_ack), 32'd1);
    check("blank_addr", 32'(tram_addr), 32'd5);
    check("blank_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    wr_req = 1'b0;
    cyc(2);

    // Pixel streams: line 0 (char 0x41 in cell 0), line 17 at 3-clk spacing, end of visible line
    mon_en = 1'b1;
    stream(797, 524, 3 + 128, 4, 1'b0);
    stream(797, 16, 3 + 64, 3, 1'b0);
    stream(621, 5, 3 + 40, 4, 1'b0);
    mon_en = 1'b0;
    check("late_clear", 32'(fetch_late), 32'd0);

    // Tick every clock: fetch cannot finish, cell is blanked and the late flag sticks
    mon_en = 1'b1;
    stream(5, 0, 11, 1, 1'b1);
    mon_en = 1'b0;
    check("late_set", 32'(fetch_late), 32'd1);
    cyc(20);
    check("late_sticky", 32'(fetch_late), 32'd1);
    reset = 1'b1;
    #1;
    check("late_reset", 32'(fetch_late), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
